digit_scan_ctrl: RTL
====================

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk_100mhz cycles each digit is driven (1 kHz per digit).
REQ-002 SHALL have parameter GUARD_CYC, default 1000, all-anodes-off cycles between digits; 0 = no guard.
REQ-003 SHALL have parameter FLASH_ROUNDS, default 125, scan rounds per flash half-period while gameover=1.
REQ-004 SHALL have port clk_100mhz  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pause  in  1  1 = hold current snapshot.
REQ-007 SHALL have port gameover  in  1  1 = flash display.
REQ-008 SHALL have port score  in  16  live BCD score {val4,val3,val2,val1}.
REQ-009 SHALL have port alt_req  in  1  alternate source (e.g. high score) requests the display.
REQ-010 SHALL have port alt_val  in  16  alternate BCD value.
REQ-011 SHALL have port alt_gnt  out  1  alternate source currently owns the display.
REQ-012 SHALL have port bval  out  4  digit code to segment decoder; 4'hF = blank.
REQ-013 SHALL have port an  out  4  active-low anodes, an[0] = least significant digit.
REQ-014 SHALL have port round_done  out  1  one-cycle pulse per completed 4-digit round.

Function
REQ-015 SHALL run a prescaler counting 0..SCAN_DIV-1 in DRIVE and 0..GUARD_CYC-1 in GUARD, cleared on each state change.
REQ-016 SHALL implement FSM states DRIVE(d) and GUARD, d = 0..3; DRIVE(d) -> GUARD after SCAN_DIV cycles; GUARD -> DRIVE((d+1) mod 4) after GUARD_CYC cycles; GUARD_CYC=0 goes DRIVE(d) -> DRIVE(d+1) directly.
REQ-017 SHALL, in DRIVE(d), output an = ~(4'b0001 << d), bval = snapshot digit d; in GUARD, an = 4'b1111, bval = 4'hF.
REQ-018 SHALL register all outputs; pins follow the FSM state with exactly one cycle of latency.
REQ-019 SHALL define round start as the entry into DRIVE(0), including the first cycle after reset release.
REQ-020 SHALL, at round start, set alt_gnt <= alt_req; grant changes only at round start, never mid-round.
REQ-021 SHALL, at round start with pause=0, load snapshot from alt_val if the new alt_gnt=1, else from score; with pause=1, keep the snapshot and alt_gnt unchanged.
REQ-022 SHALL pulse round_done for the one cycle in which DRIVE(0) is entered from the end of digit 3's interval; not on the first round after reset.
REQ-023 SHALL pass BCD digits 10..15 unchanged to bval (decoder blanks them).
REQ-024 SHALL, while gameover=1, count completed rounds and toggle a flash_off flag every FLASH_ROUNDS rounds; while flash_off=1, an = 4'b1111 in all states, with the FSM still advancing.
REQ-025 SHALL clear flash_off and the round count in the cycle after gameover falls.
REQ-026 SHALL, when pause and gameover are both 1, freeze the snapshot and keep flashing.

Reset
REQ-027 SHALL, while rst_n=0, force an=4'b1111, bval=4'hF, alt_gnt=0, round_done=0, snapshot=16'h0000, prescaler=0, flash_off=0, round count=0, state=DRIVE(0)-pending.
REQ-028 SHALL, on reset assertion mid-round, abort immediately (asynchronously); the first edge after release is a round start per REQ-019/021.

Configuration
REQ-029 SHALL, with LEADING_ZERO_BLANK_EN defined, output bval=4'hF for digit d (d=3..1) when snapshot digits d..3 are all 0; digit 0 is never blanked; anode timing is unchanged.
REQ-030 SHALL, without LEADING_ZERO_BLANK_EN, display all four digits including leading zeros.

Verification (SCAN_DIV=4, GUARD_CYC=2, FLASH_ROUNDS=2)
REQ-031 SHALL cover: score=16'h1234, release reset -> an sequence 1110/1111/1101/1111/1011/1111/0111/1111, bval 4,F,3,F,2,F,1,F, each DRIVE 4 cycles, each GUARD 2 cycles; round_done once per 24 cycles.
REQ-032 SHALL cover: alt_req=1 with alt_val=16'h9999 asserted in DRIVE(1) -> alt_gnt and bval=9 change only at next round start.
REQ-033 SHALL cover: pause=1, score changes 1234->5678 -> displayed digits stay 4,3,2,1 until pause=0 and next round start.
REQ-034 SHALL cover: gameover=1 -> an=4'b1111 for 2 rounds, normal for 2 rounds, repeating; gameover=0 -> normal from next cycle.
REQ-035 SHALL cover: LEADING_ZERO_BLANK_EN defined, score=16'h0040 -> bval F,F,4,0 for digits 3,2,1,0; score=16'h0000 -> only digit 0 shows 0.
REQ-036 SHALL cover: rst_n low during DRIVE(2) -> an=4'b1111, bval=4'hF, alt_gnt=0 asynchronously; restart at DRIVE(0) after release.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 4-digit multiplexed 7-seg scan controller with guard gaps,
// round snapshotting, alternate-source arbitration and game-over flashing.
// Ports: clk_100mhz, rst_n (async low), pause, gameover, score[15:0],
//   alt_req, alt_val[15:0] -> alt_gnt, bval[3:0] (F=blank), an[3:0] (low),
//   round_done (1-cycle pulse per completed round).
// Option: LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module digit_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYC    = 1000,
  parameter int FLASH_ROUNDS = 125
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        pause,
  input  logic        gameover,
  input  logic [15:0] score,
  input  logic        alt_req,
  input  logic [15:0] alt_val,
  output logic        alt_gnt,
  output logic [3:0]  bval,
  output logic [3:0]  an,
  output logic        round_done
);

  localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FW = (FLASH_ROUNDS > 1) ? $clog2(FLASH_ROUNDS) : 1;

  localparam logic [CW-1:0] DRV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [FW-1:0] FR_LAST  = FW'(FLASH_ROUNDS - 1);

  // PEND is the reset-held "DRIVE(0) about to start" state.
  localparam logic [1:0] ST_PEND  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   snap_q, snap_d;
  logic          gnt_q, gnt_d;
  logic          flash_q, flash_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    bval_q, bval_d;
  logic          rd_q, rd_d;

  logic          round_start;
  logic          wrap;
  logic [3:0]    cur_dig;
  logic          lz_blank;

  always_comb begin
    state_d     = state_q;
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    round_start = 1'b0;
    wrap        = 1'b0;
    unique case (1'b1)
      (state_q == ST_PEND): begin
        state_d     = ST_DRIVE;
        dig_d       = 2'd0;
        cnt_d       = '0;
        round_start = 1'b1;
      end
      (state_q == ST_DRIVE): begin
        if (cnt_q == DRV_LAST) begin
          cnt_d = '0;
          if (GUARD_CYC == 0) begin
            dig_d       = dig_q + 2'd1;
            wrap        = (dig_q == 2'd3);
            round_start = (dig_q == 2'd3);
          end else begin
            state_d = ST_GUARD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      (state_q == ST_GUARD): begin
        if (cnt_q == GRD_LAST) begin
          cnt_d       = '0;
          state_d     = ST_DRIVE;
          dig_d       = dig_q + 2'd1;
          wrap        = (dig_q == 2'd3);
          round_start = (dig_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_PEND;
        dig_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Grant and snapshot move together, and only at a round boundary.
  always_comb begin
    snap_d = snap_q;
    gnt_d  = gnt_q;
    if (round_start && !pause) begin
      gnt_d  = alt_req;
      snap_d = alt_req ? alt_val : score;
    end
  end

  always_comb begin
    flash_d = flash_q;
    fcnt_d  = fcnt_q;
    if (!gameover) begin
      flash_d = 1'b0;
      fcnt_d  = '0;
    end else if (wrap) begin
      if (fcnt_q == FR_LAST) begin
        fcnt_d  = '0;
        flash_d = ~flash_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur_dig = snap_q[3:0];
    unique case (1'b1)
      (dig_q == 2'd0): cur_dig = snap_q[3:0];
      (dig_q == 2'd1): cur_dig = snap_q[7:4];
      (dig_q == 2'd2): cur_dig = snap_q[11:8];
      default:         cur_dig = snap_q[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    unique case (1'b1)
      (dig_q == 2'd3): lz_blank = (snap_q[15:12] == 4'h0);
      (dig_q == 2'd2): lz_blank = (snap_q[15:8] == 8'h00);
      (dig_q == 2'd1): lz_blank = (snap_q[15:4] == 12'h000);
      default:         lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Live gameover gate lets the anodes recover the cycle after it drops.
  always_comb begin
    an_d   = 4'b1111;
    bval_d = 4'hF;
    rd_d   = wrap;
    if (state_q == ST_DRIVE) begin
      bval_d = lz_blank ? 4'hF : cur_dig;
      if (!(flash_q && gameover)) begin
        an_d = ~(4'b0001 << dig_q);
      end
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PEND;
      dig_q   <= 2'd0;
      cnt_q   <= '0;
      snap_q  <= 16'h0000;
      gnt_q   <= 1'b0;
      flash_q <= 1'b0;
      fcnt_q  <= '0;
      an_q    <= 4'b1111;
      bval_q  <= 4'hF;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      gnt_q   <= gnt_d;
      flash_q <= flash_d;
      fcnt_q  <= fcnt_d;
      an_q    <= an_d;
      bval_q  <= bval_d;
      rd_q    <= rd_d;
    end
  end

  assign alt_gnt    = gnt_q;
  assign an         = an_q;
  assign bval       = bval_q;
  assign round_done = rd_q;

endmodule
